// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, synchronous-read memory between the CPU memory
// interface and the I/O / program-loader port. Accesses are serialised by a
// three-state FSM (IDLE -> ACCESS [-> WAIT] -> IDLE). Ties are broken by
// strict alternation against the last granted port. Read data is returned
// through a per-port register with a one-cycle valid pulse.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cpuReq/We/Addr/Wdata CPU request; held until cpuGnt is seen
//   cpuGnt               one-cycle grant pulse (the ACCESS cycle)
//   cpuRvalid/cpuRdata   read-data valid pulse and held read data
//   io*                  same set for the I/O port
//   memEn/We/Addr/Wdata  registered command toward the memory macro
//   memRdata             memory read data, one cycle after a read access
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic                  cpuWe,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [WIDTH-1:0]      cpuWdata,
  output logic                  cpuGnt,
  output logic                  cpuRvalid,
  output logic [WIDTH-1:0]      cpuRdata,
  input  logic                  ioReq,
  input  logic                  ioWe,
  input  logic [ADDR_WIDTH-1:0] ioAddr,
  input  logic [WIDTH-1:0]      ioWdata,
  output logic                  ioGnt,
  output logic                  ioRvalid,
  output logic [WIDTH-1:0]      ioRdata,
  output logic                  memEn,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0]      memWdata,
  input  logic [WIDTH-1:0]      memRdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  state_t                r_state;
  logic                  r_last_gnt;
  logic                  r_winner;
  logic [1:0]            r_gnt;       // bit 0 = CPU, bit 1 = IO
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0]      r_mem_wdata;

  logic                  w_any_req;
  logic                  w_pick_io;

  assign w_any_req = cpuReq | ioReq;
  // IO wins when it is alone, or when both request and the CPU went last.
  assign w_pick_io = ioReq & (~cpuReq | (r_last_gnt == PORT_CPU));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= PORT_IO;   // CPU wins the first tie after reset
      r_winner    <= PORT_CPU;
      r_gnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_gnt    <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_winner    <= w_pick_io;
            r_last_gnt  <= w_pick_io;
            r_gnt       <= w_pick_io ? 2'b10 : 2'b01;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_pick_io ? ioWe : cpuWe;
            r_mem_addr  <= w_pick_io ? ioAddr : cpuAddr;
            r_mem_wdata <= w_pick_io ? ioWdata : cpuWdata;
            r_state     <= ST_ACCESS;
          end
        end
        // A write completes at the end of ACCESS; a read needs one more
        // cycle for the memory's registered output.
        ST_ACCESS: r_state <= r_mem_we ? ST_IDLE : ST_WAIT;
        ST_WAIT:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-port read-return registers; only the port that owns the pending
  // read captures memRdata, the other keeps its previous value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_SEL = (gi == 1) ? 1'b1 : 1'b0;
      logic             r_rvalid;
      logic [WIDTH-1:0] r_rdata;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
        end else begin
          r_rvalid <= 1'b0;
          if ((r_state == ST_WAIT) && (r_winner == PORT_SEL)) begin
            r_rvalid <= 1'b1;
            r_rdata  <= memRdata;
          end
        end
      end
    end
  endgenerate

  assign cpuGnt    = r_gnt[0];
  assign ioGnt     = r_gnt[1];
  assign cpuRvalid = g_port[0].r_rvalid;
  assign cpuRdata  = g_port[0].r_rdata;
  assign ioRvalid  = g_port[1].r_rvalid;
  assign ioRdata   = g_port[1].r_rdata;

  // Gate the strobes with reset so an interrupted write never reaches the
  // memory, even in the very cycle reset is first raised.
  assign memEn    = r_mem_en & ~reset;
  assign memWe    = r_mem_we & ~reset;
  assign memAddr  = r_mem_addr;
  assign memWdata = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port, synchronous-read data memory between the CPU controller's memory interface (instruction fetch and load/store) and a second requester: the I/O / program-loader port. It sits between both requesters and the memory macro. It serialises accesses, registers the address, write data and strobes toward memory, and returns registered read data with a valid pulse to the winning requester.

## Interface
Parameters:
- WIDTH, 16, data word width
- ADDR_WIDTH, 10, memory address width

Ports:
- clk  in  1  system clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high reset
- cpuReq  in  1  CPU access request; held until cpuGnt seen
- cpuWe  in  1  1 = write, 0 = read; stable while cpuReq high
- cpuAddr  in  ADDR_WIDTH  CPU address; stable while cpuReq high
- cpuWdata  in  WIDTH  CPU write data; stable while cpuReq high
- cpuGnt  out  1  one-cycle grant pulse
- cpuRvalid  out  1  one-cycle read-data-valid pulse
- cpuRdata  out  WIDTH  registered read data; holds its value until the next CPU read
- ioReq, ioWe, ioAddr, ioWdata, ioGnt, ioRvalid, ioRdata: same directions, widths and meanings as the CPU set, for the I/O port
- memEn  out  1  memory access enable
- memWe  out  1  memory write strobe
- memAddr  out  ADDR_WIDTH  memory address
- memWdata  out  WIDTH  memory write data
- memRdata  in  WIDTH  memory read data, valid one cycle after memEn with memWe=0

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: memEn high, grant pulse.
  - WAIT: memRdata valid, capture it.
- IDLE:
  - If any req is high, pick a winner and capture its addr, we and wdata into the memAddr, memWe and memWdata registers.
  - Record the winner in lastGnt and go to ACCESS. Otherwise stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - When both request, the port not equal to lastGnt wins (strict alternation).
- ACCESS:
  - memEn=1, memWe=captured we.
  - Winner's gnt=1; the other gnt stays 0.
  - Next state: IDLE if write, WAIT if read.
- WAIT:
  - memEn=0, memWe=0.
  - Capture memRdata into the winner's Rdata register.
  - Go to IDLE and pulse the winner's Rvalid during that IDLE cycle.
- Requester rule:
  - Deassert req in the cycle after gnt is seen.
  - A req still high in a later IDLE is a new request.
- memAddr and memWdata hold their last values outside ACCESS. memEn and memWe are 0 outside ACCESS.
- The loser's req is not dropped. It stays pending and wins at the next IDLE.

## Timing
- Request sampled in cycle N (IDLE).
- gnt, memEn, memAddr and memWe are valid in N+1.
- Read: memRdata valid in N+2; xRvalid=1 and xRdata=data in N+3.
- Write: memory is written at the end of N+1; the arbiter is back in IDLE in N+2.
- Throughput: one read per 3 cycles, one write per 2 cycles. The IDLE cycle carrying Rvalid also arbitrates.
- Reset values:
  - state=IDLE; lastGnt=IO, so the CPU wins the first tie.
  - All gnt, Rvalid, memEn and memWe = 0.
  - memAddr, memWdata, cpuRdata and ioRdata = 0.
- Reset mid-operation:
  - Any access in ACCESS or WAIT is abandoned.
  - No Rvalid is issued, and memWe is 0 from the first reset cycle onward.
  - The requester must reissue.
- A req asserted together with reset is ignored. It is arbitrated in the first IDLE cycle after reset deasserts.

## Test plan
- Reset held 2 cycles with both reqs high:
  - All outputs 0, no gnt.
  - After release, cpuGnt in the second cycle after reset deasserts (arbitration cycle, then ACCESS).
- Lone CPU read of addr 0x005, mem[0x005]=0xBEEF:
  - cpuGnt and memEn with memAddr=0x005 in N+1.
  - cpuRvalid=1 and cpuRdata=0xBEEF in N+3.
  - ioGnt and ioRvalid stay 0.
- Simultaneous writes after reset, CPU (0x010, 0x1111) and IO (0x011, 0x2222):
  - CPU is granted first, IO in N+3.
  - Final mem[0x010]=0x1111 and mem[0x011]=0x2222.
- Both ports issuing continuous reads:
  - Grants alternate CPU, IO, CPU, IO, 3 cycles apart.
  - Each Rvalid goes only to its own port, with the correct data.
- IO write 0xA5A5 to 0x020, then CPU read of 0x020: cpuRdata=0xA5A5.
- Reset asserted in the WAIT state of an IO read:
  - ioRvalid is never pulsed and ioRdata=0.
  - On the next simultaneous request after reset, the CPU wins.
